result_bcd_formatter: RTL
=========================

RESULT_BCD_FORMATTER -- requirements
Module: result_bcd_formatter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the signed two's-complement result from the ALU.
REQ-002 Parameter NUM_DIGITS, default 5: number of BCD digits produced, one per 7-seg display.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port i_result  input  DATA_WIDTH  signed two's-complement ALU result.
REQ-006 Port i_error  input  1  upstream error (divide-by-zero, ALU overflow).
REQ-007 Port i_valid / o_ready  input/output  1 each  upstream valid-ready handshake.
REQ-008 Port o_data  output  4*NUM_DIGITS  BCD magnitude, digit 0 in bits [3:0].
REQ-009 Port o_error  output  1  result is an error; o_data is then all zero.
REQ-010 Port o_data_is_neg  output  1  result is negative.
REQ-011 Port o_valid / i_ready  output/input  1 each  downstream handshake to the display output driver.

Function
REQ-012 A transfer occurs on a rising edge where the valid and ready of the same interface are both high.
REQ-013 The FSM SHALL have exactly three states: IDLE, CONVERT, DONE.
REQ-014 o_ready SHALL be high only in IDLE; o_valid SHALL be high only in DONE.
REQ-015 IDLE, on input transfer: capture sign = i_result MSB, magnitude = |i_result|, error = i_error, clear the BCD register and the iteration counter.
- Go to DONE if i_error is 1; otherwise go to CONVERT.
REQ-016 Magnitude SHALL be DATA_WIDTH unsigned bits, so the most negative input (0x8000 at width 16) yields magnitude 32768 without loss.
REQ-017 Each CONVERT cycle (double-dabble):
- Add 3 to every BCD digit with value >= 5.
- Shift {BCD register, magnitude} left by one bit.
- Increment the iteration counter.
REQ-018 CONVERT SHALL last exactly DATA_WIDTH cycles, then go to DONE.
- Non-error latency: o_valid first high DATA_WIDTH+1 cycles after the accept edge.
- Error latency: 1 cycle after the accept edge.
REQ-019 Digit overflow: a 1 shifted out of the top BCD digit SHALL set a sticky overflow flag.
- The flag forces o_error=1 and o_data=0 in DONE (magnitude > 10^NUM_DIGITS-1).
REQ-020 In DONE, o_data_is_neg SHALL equal the captured sign AND NOT o_error.
- A zero input gives o_data=0 and o_data_is_neg=0.
REQ-021 While o_valid=1 and i_ready=0, o_data, o_error and o_data_is_neg SHALL hold stable.
REQ-022 On output transfer, go to IDLE; o_ready is high the following cycle (no same-cycle bypass).
REQ-023 i_valid SHALL be ignored outside IDLE; upstream holds its data until o_ready.

Reset
REQ-024 While rst_n=0, asynchronously:
- State = IDLE; all registers and counters = 0.
- o_valid=0, o_data=0, o_error=0, o_data_is_neg=0, o_ready=1.
REQ-025 Reset asserted mid-CONVERT or mid-DONE SHALL abandon the result; no output transfer follows reset release until a new input is accepted.

Structure
REQ-026 Package calc_pkg SHALL hold:
- The state enum (formatter_state_t).
- BCD_DIGIT_WIDTH = 4.
REQ-027 The per-digit add-3 correction SHALL be one combinational sub-module, bcd_digit_adjust, instantiated NUM_DIGITS times.
REQ-028 The iteration counter SHALL be $clog2(DATA_WIDTH+1) bits wide.

Verification
REQ-029 i_result=0x04D2 (1234), i_ready=1 -> o_data=0x01234, neg=0, error=0; o_valid exactly 17 cycles after accept.
REQ-030 i_result=0xFFFF -> o_data=0x00001, neg=1; i_result=0x8000 -> o_data=0x32768, neg=1; i_result=0 -> o_data=0x00000, neg=0.
REQ-031 i_error=1, i_result=0x1234 -> o_error=1, o_data=0, neg=0; o_valid 1 cycle after accept.
REQ-032 NUM_DIGITS=4, i_result=0x3039 (12345) -> o_error=1, o_data=0x0000.
REQ-033 Back-to-back sequence, each checked:
- Hold i_ready=0 for 5 cycles in DONE: outputs stable, o_ready=0, i_valid ignored.
- Raise i_ready: one output transfer, then o_ready=1 the next cycle.
- Pulse rst_n low in CONVERT iteration 8: all outputs 0 and o_ready=1 immediately.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the result BCD formatter
package calc_pkg;

   localparam int BCD_DIGIT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_DONE    = 2'd2
   } formatter_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adjust
   import calc_pkg::*;
(
   input  logic [BCD_DIGIT_WIDTH-1:0] i_digit,
   output logic [BCD_DIGIT_WIDTH-1:0] o_digit
);

   // a digit of 5 or more would exceed 9 after the next shift, so pre-correct it
   always_comb begin
      o_digit = i_digit;
      if (i_digit >= BCD_DIGIT_WIDTH'(5)) begin
         o_digit = i_digit + BCD_DIGIT_WIDTH'(3);
      end
   end

endmodule

// File: rtl/result_bcd_formatter.sv
// rtl/result_bcd_formatter.sv - signed ALU result to sign/magnitude BCD for 7-seg display
module result_bcd_formatter
   import calc_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_DIGITS = 5
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [DATA_WIDTH-1:0]                 i_result,
   input  logic                                  i_error,
   input  logic                                  i_valid,
   output logic                                  o_ready,
   output logic [BCD_DIGIT_WIDTH*NUM_DIGITS-1:0] o_data,
   output logic                                  o_error,
   output logic                                  o_data_is_neg,
   output logic                                  o_valid,
   input  logic                                  i_ready
);

   localparam int BCD_WIDTH = BCD_DIGIT_WIDTH * NUM_DIGITS;
   localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);

   formatter_state_t      state_q, state_d;
   logic                  sign_q, sign_d;
   logic                  err_q, err_d;
   logic                  ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0] mag_q, mag_d;
   logic [BCD_WIDTH-1:0]  bcd_q, bcd_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [BCD_WIDTH-1:0]  bcd_adj;
   logic                  res_error;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .i_digit (bcd_q[g*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH]),
         .o_digit (bcd_adj[g*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH])
      );
   end

   // next-state: capture on accept, one double-dabble step per CONVERT cycle, release on output transfer
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      mag_d   = mag_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               sign_d  = i_result[DATA_WIDTH-1];
               // unsigned magnitude keeps the most negative input representable
               mag_d   = i_result[DATA_WIDTH-1] ? (~i_result + DATA_WIDTH'(1)) : i_result;
               err_d   = i_error;
               ovf_d   = 1'b0;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = i_error ? ST_DONE : ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            bcd_d = {bcd_adj[BCD_WIDTH-2:0], mag_q[DATA_WIDTH-1]};
            mag_d = {mag_q[DATA_WIDTH-2:0], 1'b0};
            // any 1 leaving the top digit means the value does not fit the display
            ovf_d = ovf_q | bcd_adj[BCD_WIDTH-1];
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sign_q  <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         mag_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         mag_q   <= mag_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   // outputs decode purely from registered state, so they hold while DONE is stalled
   always_comb begin
      res_error     = err_q | ovf_q;
      o_ready       = (state_q == ST_IDLE);
      o_valid       = (state_q == ST_DONE);
      o_error       = o_valid & res_error;
      o_data_is_neg = o_valid & sign_q & ~res_error;
      o_data        = (o_valid && !res_error) ? bcd_q : '0;
   end

endmodule
